// File: rtl/gray_alu_pipe.sv
// gray_alu_pipe -- three-stage pipelined Gray-code arithmetic unit.
//
// Operands arrive Gray-coded and are converted to binary in stage 1. Stage 2
// applies ADD/SUB/ACC/CLR and owns the accumulator. Stage 3 registers the
// N+1-bit result back to Gray code as {gcout, gs}. A single global advance
// enable stalls the whole pipe when a valid result is not being taken.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   in_valid/in_ready   operand handshake (in_ready = advance enable)
//   mode                00 ADD, 01 SUB, 10 ACC, 11 CLR
//   ga, gb              Gray-coded operands (gb ignored by ACC/CLR)
//   out_valid/out_ready result handshake
//   gs, gcout           Gray-coded result and carry/borrow
//   acc_g               Gray-coded accumulator, one cycle behind acc
module gray_alu_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [N-1:0] ga,
  input  logic [N-1:0] gb,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] gs,
  output logic         gcout,
  output logic [N-1:0] acc_g
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_t;

  function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b        = '0;
    b[N-1]   = g[N-1];
    for (int unsigned i = 1; i < N; i++) begin
      b[N-1-i] = b[N-i] ^ g[N-1-i];
    end
    return b;
  endfunction

  logic         en;
  logic         v1;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  mode_t        m1;
  logic         v2;
  logic [N:0]   r2;
  logic [N-1:0] acc;
  logic [N:0]   r_next;
  logic [N-1:0] acc_next;
  logic         acc_we;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // acc is read here and written on the same edge the ACC leaves S1, so a
  // following ACC already sees the updated value without a bubble.
  always_comb begin
    r_next   = '0;
    acc_next = acc;
    acc_we   = 1'b0;
    case (m1)
      MODE_ADD: r_next = {1'b0, a1} + {1'b0, b1};
      // N+1-bit wraparound leaves the borrow (A < B) in bit N.
      MODE_SUB: r_next = {1'b0, a1} - {1'b0, b1};
      MODE_ACC: begin
        r_next   = {1'b0, acc} + {1'b0, a1};
        acc_next = r_next[N-1:0];
        acc_we   = v1;
      end
      MODE_CLR: begin
        acc_next = '0;
        acc_we   = v1;
      end
      default: r_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      m1        <= MODE_ADD;
      v2        <= 1'b0;
      r2        <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      gs        <= '0;
      gcout     <= 1'b0;
      acc_g     <= '0;
    end else begin
      if (en) begin
        v1            <= in_valid;
        a1            <= gray_to_bin(ga);
        b1            <= gray_to_bin(gb);
        m1            <= mode_t'(mode);
        v2            <= v1;
        r2            <= r_next;
        out_valid     <= v2;
        {gcout, gs}   <= r2 ^ (r2 >> 1);
        if (acc_we) begin
          acc <= acc_next;
        end
      end
      acc_g <= acc ^ (acc >> 1);
    end
  end

endmodule
